// File: rtl/rx.sv
`default_nettype none
// ============================================================================
// rx : single-wire word-link serial receiver (start 0, WIDTH bits MSB first,
//      stop 0). Optional macro RX_SYNC_INPUT_EN adds a 2-flop line synchronizer.
// Revision: 1.0
// ============================================================================
module rx #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             linha,
    input  logic             ack,
    output logic [WIDTH-1:0] palavra,
    output logic             valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        DATA      = 2'd2,
        STOP      = 2'd3
    } state_t;

    logic line_in;

`ifdef RX_SYNC_INPUT_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= linha;
            sync2_q <= sync1_q;
        end
    end

    assign line_in = sync2_q;
`else
    assign line_in = linha;
`endif

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   shreg_q,   shreg_d;
    logic               good_q,    good_d;
    logic               bad_q,     bad_d;
    logic [WIDTH-1:0]   palavra_q, palavra_d;
    logic               valid_q,   valid_d;
    logic               overrun_q, overrun_d;
    logic               ferr_q,    ferr_d;
    logic               busy_q,    busy_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= WAIT_HIGH;
            cnt_q     <= '0;
            shreg_q   <= '0;
            good_q    <= 1'b0;
            bad_q     <= 1'b0;
            palavra_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            palavra_q <= palavra_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    // Frame FSM; WAIT_HIGH keeps a stop bit or stuck-low line from looking like a start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            WAIT_HIGH: begin
                if (line_in) state_d = IDLE;
            end
            IDLE: begin
                if (!line_in) begin
                    state_d = DATA;
                    cnt_d   = CNT_W'(WIDTH - 1);
                end
            end
            DATA: begin
                shreg_d = {shreg_q[WIDTH-2:0], line_in};
                if (cnt_q == '0) state_d = STOP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            STOP: begin
                state_d = WAIT_HIGH;
                if (line_in) bad_d  = 1'b1;
                else         good_d = 1'b1;
            end
            default: state_d = WAIT_HIGH;
        endcase
    end

    // Output holding register; shreg_q is stable until the next DATA state
    always_comb begin
        palavra_d = palavra_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (good_q) begin
            if (!valid_q || ack) begin
                palavra_d = shreg_q;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        ferr_d = bad_q;
        busy_d = (state_d == DATA) || (state_d == STOP);
    end

    assign palavra   = palavra_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rx.sv
`default_nettype none
// ============================================================================
// tb_rx : directed self-checking bench for rx (WIDTH=16, no input sync).
// Revision: 1.0
// ============================================================================
module tb_rx;

    localparam int WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             linha;
    logic             ack;
    logic [WIDTH-1:0] palavra;
    logic             valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    rx #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .linha     (linha),
        .ack       (ack),
        .palavra   (palavra),
        .valid     (valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after each rising edge; outputs are read there too
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [WIDTH-1:0] word, input logic stop_bit);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            linha = word[i];
            tick();
        end
        linha = stop_bit;
        tick();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] word, input logic stop_bit);
        linha = 1'b0;
        tick();
        send_bits(word, stop_bit);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        linha = 1'b1;
        ack   = 1'b0;
        tick();
        tick();
        checks++;
        if ({palavra, valid, busy, frame_err, overrun} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: palavra=%h valid=%b busy=%b ferr=%b ovr=%b required all 0",
                     palavra, valid, busy, frame_err, overrun);
        end
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single_frame();
        logic [WIDTH-1:0] word;
        int               busy_bad;
        word     = 16'hA5C3;
        busy_bad = 0;
        linha = 1'b0;
        tick();
        if (busy !== 1'b1) busy_bad++;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            linha = word[i];
            tick();
            if (busy !== 1'b1) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL single_busy_high: %0d cycles busy low, required 0", busy_bad);
        end
        linha = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL single_after_stop: busy=%b valid=%b required 0 0", busy, valid);
        end
        linha = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || palavra !== 16'hA5C3 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL single_word: valid=%b palavra=%h ferr=%b required 1 a5c3 0",
                     valid, palavra, frame_err);
        end
        do_ack();
        checks++;
        if (valid !== 1'b0 || palavra !== 16'hA5C3) begin
            failures++;
            $display("FAIL single_ack: valid=%b palavra=%h required 0 a5c3", valid, palavra);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(16'h0001, 1'b0);
        linha = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || palavra !== 16'h0001) begin
            failures++;
            $display("FAIL b2b_first: valid=%b palavra=%h required 1 0001", valid, palavra);
        end
        ack   = 1'b1;
        linha = 1'b0;
        tick();
        ack   = 1'b0;
        send_bits(16'hFFFF, 1'b0);
        linha = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || palavra !== 16'hFFFF || overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: valid=%b palavra=%h ovr=%b required 1 ffff 0",
                     valid, palavra, overrun);
        end
        do_ack();
    endtask

    task automatic test_frame_error();
        send_frame(16'h1234, 1'b1);
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL ferr_early: frame_err=%b required 0", frame_err);
        end
        linha = 1'b1;
        tick();
        checks++;
        if (frame_err !== 1'b1 || valid !== 1'b0 || palavra !== 16'hFFFF || overrun !== 1'b0) begin
            failures++;
            $display("FAIL ferr_pulse: ferr=%b valid=%b palavra=%h ovr=%b required 1 0 ffff 0",
                     frame_err, valid, palavra, overrun);
        end
        linha = 1'b0;
        tick();
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL ferr_one_cycle: frame_err=%b required 0", frame_err);
        end
        send_bits(16'h00FF, 1'b0);
        linha = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || palavra !== 16'h00FF) begin
            failures++;
            $display("FAIL ferr_recover: valid=%b palavra=%h required 1 00ff", valid, palavra);
        end
        do_ack();
    endtask

    task automatic test_overrun();
        send_frame(16'hBEEF, 1'b0);
        linha = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || palavra !== 16'hBEEF || overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_first: valid=%b palavra=%h ovr=%b required 1 beef 0",
                     valid, palavra, overrun);
        end
        send_frame(16'hCAFE, 1'b0);
        linha = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || palavra !== 16'hBEEF || overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_set: valid=%b palavra=%h ovr=%b required 1 beef 1",
                     valid, palavra, overrun);
        end
        do_ack();
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b0 || palavra !== 16'hBEEF) begin
            failures++;
            $display("FAIL ovr_clear: valid=%b ovr=%b palavra=%h required 0 0 beef",
                     valid, overrun, palavra);
        end
    endtask

    task automatic test_reset_mid_frame();
        int busy_bad;
        busy_bad = 0;
        linha = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            linha = i[0];
            tick();
        end
        reset = 1'b0;
        linha = 1'b0;
        tick();
        checks++;
        if ({palavra, valid, busy, frame_err, overrun} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: palavra=%h valid=%b busy=%b ferr=%b ovr=%b required all 0",
                     palavra, valid, busy, frame_err, overrun);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy !== 1'b0) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL midreset_stuck_low: busy high %0d cycles, required 0", busy_bad);
        end
        linha = 1'b1;
        tick();
        send_frame(16'h5A5A, 1'b0);
        linha = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || palavra !== 16'h5A5A) begin
            failures++;
            $display("FAIL midreset_recover: valid=%b palavra=%h required 1 5a5a", valid, palavra);
        end
        do_ack();
    endtask

    task automatic test_ack_collision();
        send_frame(16'h1111, 1'b0);
        linha = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b1 || palavra !== 16'h1111) begin
            failures++;
            $display("FAIL coll_old: valid=%b palavra=%h required 1 1111", valid, palavra);
        end
        send_frame(16'h2222, 1'b0);
        linha = 1'b1;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        checks++;
        if (valid !== 1'b1 || palavra !== 16'h2222 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL coll_new: valid=%b palavra=%h ovr=%b required 1 2222 0",
                     valid, palavra, overrun);
        end
    endtask

    initial begin
        reset = 1'b0;
        linha = 1'b1;
        ack   = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_ack_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
